// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// funct3 access-size codes and the BUSY timeout counter width.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned TMR_W               = 8;
    localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/acknowledge data-memory bus between the load/store unit (master)
// and the variable-latency data memory (slave).
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load lane extraction with sign/zero extension, and access fault detect.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic        fault
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be       = 4'b0000;
        wdata    = store_data;
        load_ext = 32'd0;
        fault    = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be       = 4'b0001 << offset;
                wdata    = {4{store_data[7:0]}};
                load_ext = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                            : {24'd0, byte_sel};
                fault    = is_store && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                be       = 4'b0011 << {offset[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
                load_ext = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                            : {16'd0, half_sel};
                fault    = offset[0] || (is_store && (funct3 == F3_HU));
            end
            F3_W: begin
                be       = 4'b1111;
                load_ext = rdata;
                fault    = (offset != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/BUSY/DONE sequencer that runs one request/ack memory
// transaction per load or store and stalls the PC. Optional macro LSU_TIMEOUT_EN
// aborts a BUSY access after TIMEOUT_CYCLES cycles without ack.
module load_store_unit
    import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
)
`endif
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              store_data,
    output logic [31:0]              load_data,
    output logic                     stall,
    output logic                     mem_fault,
    output logic                     bus_err,
    load_store_unit_if.master        bus
);
    lsu_state_e  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        mem_fault_q, mem_fault_d;
    logic        err_flag;

    logic        in_idle;
    logic [2:0]  f3_sel;
    logic [1:0]  off_sel;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_fault;

`ifdef LSU_TIMEOUT_EN
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             bus_err_q, bus_err_d;
`endif

    // In IDLE the aligner sees the live instruction; afterwards it sees the
    // captured size/offset so the same instance extracts the load lane.
    assign in_idle = (state_q == IDLE);
    assign f3_sel  = in_idle ? funct3    : f3_q;
    assign off_sel = in_idle ? addr[1:0] : off_q;

    lsu_lane_align u_lane_align (
        .funct3     (f3_sel),
        .offset     (off_sel),
        .is_store   (MemWrite),
        .store_data (store_data),
        .rdata      (rdata_q),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_ext   (al_load),
        .fault      (al_fault)
    );

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_fault_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
        tmr_d       = tmr_q;
        bus_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    f3_d  = funct3;
                    off_d = addr[1:0];
                    if (al_fault) begin
                        mem_fault_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemWrite;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = al_be;
                        bus_wdata_d = al_wdata;
                        state_d     = BUSY;
`ifdef LSU_TIMEOUT_EN
                        tmr_d       = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
            end
            BUSY: begin
                if (bus.bus_ack) begin
                    rdata_d   = bus.bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
`ifdef LSU_TIMEOUT_EN
                end else if (tmr_q == '0) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_fault_q <= mem_fault_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign err_flag = bus_err_q;
`else
    assign err_flag = 1'b0;
`endif

    assign bus_err       = err_flag;
    assign mem_fault     = mem_fault_q;
    assign stall         = (state_q == BUSY) || (in_idle && (MemRead || MemWrite));
    // Faulted, timed-out and store accesses all return zero in DONE.
    assign load_data     = (state_q == DONE && !mem_fault_q && !err_flag && !bus_we_q)
                           ? al_load : 32'd0;

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses against a byte-lane arithmetic reference model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, mem_fault, bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit_if bus_if ();

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .mem_fault  (mem_fault),
        .bus_err    (bus_err),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, lanes computed arithmetically.
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic m_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        if (sz == 0) return 1'b1;
        if (wr && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
        return (int'(a % 4) % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        int v = ((1 << sz) - 1) << int'(a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = m_size(f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * int'(a % 4));
        case (f3)
            3'b000: v = {{24{v[7]}}, v[7:0]};
            3'b100: v = {24'd0, v[7:0]};
            3'b001: v = {{16{v[15]}}, v[15:0]};
            3'b101: v = {16'd0, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    // Starts at a falling edge with the DUT in IDLE; ends at a falling edge in IDLE.
    // ack_wait = BUSY cycles without ack before the ack cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdat, input int ack_wait,
                              input logic exp_timeout);
        logic        flt = m_fault(wr, f3, a);
        int          exp_cycles;
        int          cycles = 1;
        int          busy = 0;
        logic [31:0] exp_ld;
        if (flt)              exp_cycles = 1;
        else if (exp_timeout) exp_cycles = 1 + 16;
        else                  exp_cycles = 2 + ack_wait;
        exp_ld = (flt || wr || exp_timeout) ? 32'd0 : m_load(f3, a, rdat);

        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; store_data = sd;
        bus_if.bus_ack = 1'b0;
        #1;
        chk("stall_idle", {31'd0, stall}, 32'd1);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            bus_if.bus_ack = 1'b0;
            #1;
            if (!stall) break;
            cycles++;
            if (busy == 0) begin
                chk("bus_req",   {31'd0, bus_if.bus_req}, 32'd1);
                chk("bus_we",    {31'd0, bus_if.bus_we}, {31'd0, wr});
                chk("bus_addr",  bus_if.bus_addr, {a[31:2], 2'b00});
                chk("bus_be",    {28'd0, bus_if.bus_be}, {28'd0, m_be(f3, a)});
                if (wr) chk("bus_wdata", bus_if.bus_wdata, m_wdata(f3, sd));
            end
            if (busy == ack_wait) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = rdat;
            end else begin
                bus_if.bus_rdata = $urandom;
            end
            busy++;
        end
        chk("stall_cycles", cycles, exp_cycles);
        chk("load_data",    load_data, exp_ld);
        chk("mem_fault",    {31'd0, mem_fault}, {31'd0, flt});
        chk("bus_err",      {31'd0, bus_err}, {31'd0, exp_timeout});
        chk("req_done",     {31'd0, bus_if.bus_req}, 32'd0);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        chk("stall_nomem", {31'd0, stall}, 32'd0);
        chk("fault_clr",   {31'd0, mem_fault}, 32'd0);
    endtask

    initial begin
        logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] bad_f3 [3]   = '{3'b011, 3'b110, 3'b111};
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
        addr = 32'd0; store_data = 32'd0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_req",   {31'd0, bus_if.bus_req}, 32'd0);
        chk("rst_we",    {31'd0, bus_if.bus_we}, 32'd0);
        chk("rst_addr",  bus_if.bus_addr, 32'd0);
        chk("rst_be",    {28'd0, bus_if.bus_be}, 32'd0);
        chk("rst_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst_ld",    load_data, 32'd0);
        chk("rst_flt",   {31'd0, mem_fault}, 32'd0);
        chk("rst_err",   {31'd0, bus_err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_access(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0);
        run_access(1, 0, 3'b000, 32'h13, 32'h0, 32'h80FF0000, 0, 0);
        run_access(1, 0, 3'b100, 32'h13, 32'h0, 32'h80FF0000, 0, 0);
        run_access(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 32'hFFFFFFFF, 2, 0);
        run_access(1, 0, 3'b010, 32'h11, 32'h0, 32'h12345678, 0, 0);
        run_access(0, 1, 3'b100, 32'h20, 32'h55, 32'h0, 0, 0);
        run_access(1, 1, 3'b000, 32'h31, 32'hA5, 32'h77777777, 0, 0);

        // Stray ack in IDLE must be ignored.
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #1;
        chk("stray_req",   {31'd0, bus_if.bus_req}, 32'd0);
        chk("stray_stall", {31'd0, stall}, 32'd0);
        run_access(1, 0, 3'b001, 32'h42, 32'h0, 32'hC0017FFF, 0, 0);

        // Reset in the middle of BUSY abandons the transaction.
        MemRead = 1'b1; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        #1;
        chk("mid_req_hi", {31'd0, bus_if.bus_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_req_lo", {31'd0, bus_if.bus_req}, 32'd0);
        chk("mid_stall",  {31'd0, stall}, 32'd1);
        MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_access(1, 0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D, 0, 0);

`ifdef LSU_TIMEOUT_EN
        run_access(1, 0, 3'b010, 32'h50, 32'h0, 32'h11111111, 1000, 1);
        run_access(1, 0, 3'b010, 32'h54, 32'h0, 32'h22222222, 15, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            int          op = $urandom_range(0, 2);
            logic [2:0]  f3;
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 7) == 0) f3 = bad_f3[$urandom_range(0, 2)];
            else                           f3 = legal_f3[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_access(op != 1, op != 0, f3, a, $urandom, $urandom,
                       $urandom_range(0, 4), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the ALU and the data-memory bus. Takes the ALU-computed address, the rs2 store data and the control unit's MemRead/MemWrite, and runs a request/acknowledge transaction to a variable-latency data memory. Generates byte enables, performs byte/halfword lane alignment and load sign/zero extension, and stalls the program counter until the access completes. Its output feeds the MemtoReg write-back mux.

## Interface
- TIMEOUT_CYCLES, 16: maximum BUSY cycles before abort (only with LSU_TIMEOUT_EN).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store; wins if both are high.
- funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- addr  in  32  byte address from ALU_Result.
- store_data  in  32  rs2 value.
- load_data  out  32  extended load result; valid in DONE.
- stall  out  1  hold PC / suppress RegWrite while high.
- mem_fault  out  1  one-cycle pulse in DONE for a misaligned or illegal access.
- bus_req  out  1  request; held until ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read word; sampled with ack.
- bus_ack  in  1  completion; one-cycle pulse.
- bus_err  out  1  one-cycle pulse in DONE on timeout (LSU_TIMEOUT_EN only; tied 0 otherwise).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if MemRead|MemWrite, stall=1 combinationally.
  - Legal, aligned access: register bus_req=1, bus_we, bus_addr, bus_be and bus_wdata; go to BUSY.
  - Fault: go directly to DONE with fault flag set; no bus request.
- BUSY: stall=1; bus outputs held stable. On bus_ack: capture bus_rdata into rdata_q, drop bus_req, go to DONE.
- DONE: stall=0 for exactly one cycle; load_data valid; mem_fault/bus_err pulse if flagged; go to IDLE. The PC advances on the edge that ends DONE.
- Alignment rules:
  - H/HU require addr[0]=0; W requires addr[1:0]=00.
  - Fault cases: any misalignment; funct3 ∉ {000,001,010,100,101}; store with funct3 100/101.
- Byte enables:
  - B: 0001<<addr[1:0].
  - H: 0011<<{addr[1],1'b0}.
  - W: 1111.
- Write data:
  - SB: {4{store_data[7:0]}}.
  - SH: {2{store_data[15:0]}}.
  - SW: store_data.
- Loads select the lane with addr[1:0]; B/H sign-extend, BU/HU zero-extend. A faulting access returns load_data=0.
- Stores: load_data=0 in DONE.
- bus_ack outside BUSY is ignored.

## Timing
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, load_data 0, mem_fault 0, bus_err 0, rdata_q 0. stall=0 after reset (it is combinational from the inputs while in IDLE).
- Asserting reset mid-BUSY drops bus_req asynchronously; the transaction is abandoned.
- Minimum access: 3 cycles (IDLE, BUSY with ack in first BUSY cycle, DONE).
- Fault access: 2 cycles (IDLE, DONE).
- Non-memory instructions: 0 stall cycles.
- bus_req rises the cycle after the request is seen in IDLE. The earliest accepted ack is the first BUSY cycle.
- Back-to-back memory instructions: the second starts in the IDLE cycle after DONE. No overlap.

## Configuration
- LSU_TIMEOUT_EN defined: an 8-bit counter runs in BUSY.
  - If TIMEOUT_CYCLES elapse without ack, drop bus_req and go to DONE with bus_err=1 and load_data=0.
  - A late ack is then ignored.
- Not defined: BUSY waits indefinitely; bus_err is constant 0.

## Structure
- Package lsu_pkg: state enum (IDLE, BUSY, DONE), funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), timeout counter width.
- One sub-module, lsu_lane_align: combinational byte-enable, write-data replication, load extraction/extension, and fault detect. Instantiated once.

## Test plan
- LW addr 0x10, ack after 2 BUSY cycles with rdata 0xDEADBEEF → bus_addr 0x10, be 1111, stall high 3 cycles, load_data 0xDEADBEEF in DONE.
- LB addr 0x13, rdata 0x80FF_0000 → be 1000, load_data 0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x22, store_data 0x1234ABCD → bus_we 1, be 1100, wdata 0xABCDABCD, load_data 0.
- LW addr 0x11 → no bus_req, mem_fault pulse in 2nd cycle, stall high 1 cycle, load_data 0.
- Reset asserted mid-BUSY → bus_req 0 immediately, state IDLE; next LW completes normally.
- With LSU_TIMEOUT_EN and no ack → bus_req drops after 16 BUSY cycles, bus_err pulses, load_data 0.
